mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width (32 or 64).
REQ-002 SHALL have parameter UNALIGNED_EN, default 1, enabling LWL/LWR/SWL/SWR.
REQ-003 SHALL have parameter MAX_WAIT, default 15, response-timeout cycle count.
REQ-004 SHALL derive BE_W = DATA_W/8 and OFF_W = log2(BE_W) as localparams.
REQ-005 SHALL have ports, one clock and one reset: reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  pipeline memory request
- req_ready  out  1  unit can accept a request
- op  in  6  MIPS primary opcode
- addr  in  32  effective address
- wdata  in  32  store source (rt)
- rt_old  in  32  old rt value, used for LWL/LWR merge
- flush  in  1  exception/flush; abandon the in-flight access
- mem_en  out  1  bus request strobe
- mem_wen  out  BE_W  byte write enables, 0 for loads
- mem_addr  out  32  bus address
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  bus read data
- mem_rvalid  in  1  bus access complete
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended/merged load result
- adel / ades  out  1 each  load/store address error, valid with resp_valid
- badvaddr  out  32  faulting address, valid with adel|ades
- timeout  out  1  bus did not respond within MAX_WAIT cycles
- stall  out  1  req_valid & ~resp_valid

Function
REQ-006 SHALL use FSM states IDLE, ISSUE, WAIT, RESP, DRAIN; req_ready = (state==IDLE).
REQ-007 IDLE + req_valid: SHALL latch op/addr/wdata/rt_old; move to RESP if misaligned or op illegal, otherwise to ISSUE.
REQ-008 Misalignment SHALL be defined as: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]=1; LB/LBU/SB, LWL/LWR/SWL/SWR never misaligned.
REQ-009 An unaligned op with UNALIGNED_EN=0 SHALL be treated as a reserved op: adel for loads, ades for stores.
REQ-010 ISSUE SHALL assert mem_en for exactly one cycle, then move to WAIT.
REQ-011 mem_addr SHALL be the word-aligned address for loads and the full address for stores.
REQ-012 mem_wen SHALL select lanes addressed by addr[OFF_W-1:0]: SB one byte, SH two bytes, SW four bytes.
REQ-013 SWL SHALL write bytes addr[1:0]..0 and SWR SHALL write bytes 3..addr[1:0] (little-endian), with mem_wdata shifted to match.
REQ-014 For DATA_W=64, the enables and data SHALL be placed in the half selected by addr[2].
REQ-015 In WAIT, mem_rvalid SHALL capture the result and move to RESP; a 4-bit counter SHALL increment on each cycle without a response.
REQ-016 When the counter reaches MAX_WAIT, the FSM SHALL move to RESP with timeout=1 and resp_rdata=0.
REQ-017 Load extraction SHALL be:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: pass through.
- LWL/LWR: merge memory bytes into rt_old per MIPS32 little-endian rules.
REQ-018 Stores SHALL return resp_rdata=0.
REQ-019 RESP SHALL hold resp_valid=1 for exactly one cycle, then return to IDLE.
REQ-020 A flush in ISSUE or WAIT SHALL move the FSM to DRAIN with no resp_valid.
REQ-021 DRAIN SHALL wait for mem_rvalid (or timeout), discard the data, then go to IDLE.
REQ-022 A flush in IDLE or RESP SHALL suppress that cycle's acceptance or response.
REQ-023 If flush and mem_rvalid occur in the same cycle in WAIT, the FSM SHALL go to IDLE with no response.
REQ-024 Accepted-to-resp_valid latency SHALL be 3 cycles minimum for a bus with zero-wait mem_rvalid.
REQ-025 An error response SHALL take 1 cycle (IDLE->RESP).

Reset
REQ-026 rst SHALL force:
- state=IDLE, counter=0.
- mem_en=0, mem_wen=0, resp_valid=0.
- adel=ades=timeout=0.
- resp_rdata=0, badvaddr=0, latched request registers=0.
REQ-027 rst asserted mid-access SHALL abandon it immediately; a late mem_rvalid arriving in IDLE SHALL be ignored.

Structure
REQ-028 Opcode constants (LB..SWR) SHALL come from the shared defines header; FSM state encodings SHALL be local to the module.
REQ-029 Load extraction/merge SHALL be a combinational sub-module load_align(op, off, rdata, rt_old -> result).

Verification
REQ-030 LB, addr=0x1003, mem_rdata=0x80FF_0000 -> resp_rdata=0xFFFF_FF80, latency 3.
REQ-031 SH, addr=0x2002, wdata=0x1234 -> mem_wen=4'b1100, mem_wdata=0x1234_1234.
REQ-032 LW, addr=0x3001 -> adel=1, badvaddr=0x3001, mem_en never asserted, resp one cycle after accept.
REQ-033 LWL, addr=0x4001, mem_rdata=0xAABB_CCDD, rt_old=0x1122_3344 -> resp_rdata=0xCCDD_3344.
REQ-034 Flush one cycle after ISSUE, mem_rvalid two cycles later -> no resp_valid, req_ready returns after the drain.
REQ-035 mem_rvalid never asserted -> timeout=1 after MAX_WAIT WAIT cycles; rst mid-WAIT -> IDLE next cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcode constants and opcode classification helpers for the memory access unit.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load = 1'b1;
      default:                                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_store = 1'b1;
      default:                             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_unaligned_op(input logic [5:0] op);
    case (op)
      OP_LWL, OP_LWR, OP_SWL, OP_SWR: is_unaligned_op = 1'b1;
      default:                        is_unaligned_op = 1'b0;
    endcase
  endfunction

  // Word accesses need a 4-byte boundary, halfword accesses a 2-byte boundary.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:          is_misaligned = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH:  is_misaligned = off[0];
      default:               is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Load extraction: byte/halfword extension and little-endian LWL/LWR merge into rt.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/halfword and shape the register result
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    result   = '0;
    case (op)
      OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: result = {24'h000000, byte_sel};
      OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      OP_LHU: result = {16'h0000, half_sel};
      OP_LW:  result = rdata;
      OP_LWL: begin
        case (off)
          2'd0: result = {rdata[7:0],  rt_old[23:0]};
          2'd1: result = {rdata[15:0], rt_old[15:0]};
          2'd2: result = {rdata[23:0], rt_old[7:0]};
          2'd3: result = rdata;
        endcase
      end
      OP_LWR: begin
        case (off)
          2'd0: result = rdata;
          2'd1: result = {rt_old[31:24], rdata[31:8]};
          2'd2: result = {rt_old[31:16], rdata[31:16]};
          2'd3: result = {rt_old[31:8],  rdata[31:24]};
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-to-bus memory access unit: alignment checks, store lane steering,
// single-beat bus handshake with timeout, flush draining and load result shaping.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int UNALIGNED_EN = 1,
  parameter int MAX_WAIT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            op,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [31:0]           rt_old,
  input  logic                  flush,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic [31:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  adel,
  output logic                  ades,
  output logic [31:0]           badvaddr,
  output logic                  timeout,
  output logic                  stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rt_old_q;
  logic        mem_en_q;
  logic        resp_valid_q;
  logic        adel_q;
  logic        ades_q;
  logic        timeout_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] badvaddr_q;

  logic        req_err;
  logic        req_is_store;
  logic        wait_expired;
  logic [3:0]  wen4;
  logic [31:0] wd32;
  logic [BE_W-1:0] wen_full;
  logic [31:0] rdata32;
  logic [31:0] ld_result;

  assign cnt_d        = cnt_q + 4'd1;
  assign wait_expired = (cnt_d == 4'(MAX_WAIT));
  assign req_is_store = is_store(op);

  // Classify the incoming request: illegal opcode, disabled unaligned op, or misaligned address
  always_comb begin
    req_err = 1'b0;
    if (!is_load(op) && !req_is_store)             req_err = 1'b1;
    if (is_unaligned_op(op) && (UNALIGNED_EN == 0)) req_err = 1'b1;
    if (is_misaligned(op, addr[1:0]))              req_err = 1'b1;
  end

  // Byte enables and write data for the latched store, steered into the addressed half
  always_comb begin
    wen4 = 4'b0000;
    wd32 = wdata_q;
    case (op_q)
      OP_SB:  begin wen4 = 4'b0001 << addr_q[1:0]; wd32 = {4{wdata_q[7:0]}};  end
      OP_SH:  begin wen4 = 4'b0011 << addr_q[1:0]; wd32 = {2{wdata_q[15:0]}}; end
      OP_SW:  begin wen4 = 4'b1111;                wd32 = wdata_q;             end
      OP_SWL: begin
        wen4 = 4'b1111 >> (2'd3 - addr_q[1:0]);
        wd32 = wdata_q >> {(2'd3 - addr_q[1:0]), 3'b000};
      end
      OP_SWR: begin
        wen4 = 4'b1111 << addr_q[1:0];
        wd32 = wdata_q << {addr_q[1:0], 3'b000};
      end
      default: ;
    endcase
    wen_full = BE_W'(wen4);
    if ((BE_W == 8) && addr_q[OFF_W-1]) wen_full = wen_full << 4;
  end

  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_en_q ? wen_full : '0;
  assign mem_addr  = is_store(op_q) ? addr_q : {addr_q[31:2], 2'b00};
  assign mem_wdata = {(DATA_W/32){wd32}};

  assign rdata32 = ((BE_W == 8) && addr_q[OFF_W-1]) ? mem_rdata[DATA_W-1 -: 32] : mem_rdata[31:0];

  load_align u_load_align (
    .op     (op_q),
    .off    (addr_q[1:0]),
    .rdata  (rdata32),
    .rt_old (rt_old_q),
    .result (ld_result)
  );

  // Access sequencing with registered bus strobe and response flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rt_old_q     <= '0;
      mem_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      timeout_q    <= 1'b0;
      resp_rdata_q <= '0;
      badvaddr_q   <= '0;
    end else begin
      mem_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      timeout_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            op_q     <= op;
            addr_q   <= addr;
            wdata_q  <= wdata;
            rt_old_q <= rt_old;
            cnt_q    <= '0;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              adel_q       <= !req_is_store;
              ades_q       <= req_is_store;
              badvaddr_q   <= addr;
              resp_rdata_q <= '0;
            end else begin
              state_q  <= S_ISSUE;
              mem_en_q <= 1'b1;
            end
          end
        end
        S_ISSUE: state_q <= flush ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= is_load(op_q) ? ld_result : '0;
            end
          end else if (wait_expired) begin
            // An expiring wait under flush has nothing left to drain
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              timeout_q    <= 1'b1;
              resp_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
            if (flush) state_q <= S_DRAIN;
          end
        end
        S_RESP: state_q <= S_IDLE;
        S_DRAIN: begin
          if (mem_rvalid || wait_expired) state_q <= S_IDLE;
          else                            cnt_q   <= cnt_d;
        end
      endcase
    end
  end

  // A flush during the response cycle cancels the completion
  assign resp_valid = resp_valid_q & ~flush;
  assign adel       = adel_q & ~flush;
  assign ades       = ades_q & ~flush;
  assign timeout    = timeout_q & ~flush;
  assign resp_rdata = resp_rdata_q;
  assign badvaddr   = badvaddr_q;
  assign req_ready  = (state_q == S_IDLE);
  assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rt_old;
  logic        flush;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;
  logic        timeout;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .UNALIGNED_EN(1), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .rt_old     (rt_old),
    .flush      (flush),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .adel       (adel),
    .ades       (ades),
    .badvaddr   (badvaddr),
    .timeout    (timeout),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_load(input logic [5:0] f_op);
    return (f_op == OP_LB) || (f_op == OP_LH) || (f_op == OP_LW) || (f_op == OP_LBU) ||
           (f_op == OP_LHU) || (f_op == OP_LWL) || (f_op == OP_LWR);
  endfunction

  function automatic bit m_is_store(input logic [5:0] f_op);
    return (f_op == OP_SB) || (f_op == OP_SH) || (f_op == OP_SW) ||
           (f_op == OP_SWL) || (f_op == OP_SWR);
  endfunction

  // Address error: word ops need addr%4==0, halfword ops addr%2==0, unknown ops always fault
  function automatic bit m_err(input logic [5:0] f_op, input logic [31:0] a);
    int unsigned rem4;
    rem4 = a % 4;
    if (f_op == OP_LW || f_op == OP_SW) return rem4 != 0;
    if (f_op == OP_LH || f_op == OP_LHU || f_op == OP_SH) return (rem4 % 2) != 0;
    return !(m_is_load(f_op) || m_is_store(f_op));
  endfunction

  // Cycle (counted from the accept cycle) in which the access finishes
  function automatic int end_cyc(input bit err, input int dly);
    if (err) return 1;
    return (3 + dly < 2 + MAX_WAIT) ? 3 + dly : 2 + MAX_WAIT;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] f_op, input int off,
                                         input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  mb [4];
    logic [7:0]  rb [4];
    logic [7:0]  res [4];
    int hi;
    for (int i = 0; i < 4; i++) begin
      mb[i] = mem[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    hi = (off + 1) % 4;
    case (f_op)
      OP_LB:  return {{24{mb[off][7]}}, mb[off]};
      OP_LBU: return {24'h0, mb[off]};
      OP_LH:  return {{16{mb[hi][7]}}, mb[hi], mb[off]};
      OP_LHU: return {16'h0, mb[hi], mb[off]};
      OP_LW:  return mem;
      OP_LWL: for (int i = 0; i < 4; i++) res[i] = (i >= 3 - off) ? mb[i - (3 - off)] : rb[i];
      OP_LWR: for (int i = 0; i < 4; i++) res[i] = (i <= 3 - off) ? mb[i + off] : rb[i];
      default: return 32'h0;
    endcase
    return {res[3], res[2], res[1], res[0]};
  endfunction

  // Expected bus byte enables and data; mask marks the bytes whose value is defined
  function automatic void m_store(input logic [5:0] f_op, input int off, input logic [31:0] rt,
                                  output logic [3:0] wen, output logic [31:0] data,
                                  output logic [31:0] mask);
    logic [7:0] rb [4];
    for (int i = 0; i < 4; i++) rb[i] = rt[8*i +: 8];
    wen = '0; data = '0; mask = '0;
    for (int j = 0; j < 4; j++) begin
      case (f_op)
        OP_SB: begin
          wen[j] = (j == off); data[8*j +: 8] = rb[0]; mask[8*j +: 8] = 8'hFF;
        end
        OP_SH: begin
          wen[j] = (j == off) || (j == off + 1); data[8*j +: 8] = rb[j % 2]; mask[8*j +: 8] = 8'hFF;
        end
        OP_SW: begin
          wen[j] = 1'b1; data[8*j +: 8] = rb[j]; mask[8*j +: 8] = 8'hFF;
        end
        OP_SWL: if (j <= off) begin
          wen[j] = 1'b1; data[8*j +: 8] = rb[j + 3 - off]; mask[8*j +: 8] = 8'hFF;
        end
        OP_SWR: if (j >= off) begin
          wen[j] = 1'b1; data[8*j +: 8] = rb[j - off]; mask[8*j +: 8] = 8'hFF;
        end
        default: ;
      endcase
    end
  endfunction

  // One access: dly = bus wait after the strobe cycle, fl = cycle to pulse flush (0 = none)
  task automatic run_txn(input logic [5:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_wd,
                         input logic [31:0] t_rt, input logic [31:0] t_rd, input int dly, input int fl);
    bit err, ld, st, to;
    int e_cyc, ready_exp, ready_cyc, en_cnt, resp_cnt, off;
    logic [3:0]  wen_exp;
    logic [31:0] wd_exp, wd_mask, rd_exp;
    err = m_err(t_op, t_addr);
    ld  = m_is_load(t_op);
    st  = m_is_store(t_op);
    off = int'(t_addr % 4);
    to  = !err && (dly >= MAX_WAIT);
    e_cyc     = end_cyc(err, dly);
    ready_exp = (fl > 0 && fl < e_cyc) ? e_cyc : e_cyc + 1;
    m_store(t_op, off, t_wd, wen_exp, wd_exp, wd_mask);
    rd_exp = (err || !ld || to) ? 32'h0 : m_load(t_op, off, t_rd, t_rt);

    req_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wd; rt_old = t_rt;
    flush = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check("accept_ready", 32'(req_ready), 32'd1);
    check("accept_stall", 32'(stall), 32'd1);

    ready_cyc = 0; en_cnt = 0; resp_cnt = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      req_valid  = 1'b0;
      op         = 6'($urandom);
      addr       = $urandom;
      wdata      = $urandom;
      rt_old     = $urandom;
      flush      = (cyc == fl);
      mem_rvalid = !err && (cyc == 2 + dly);
      mem_rdata  = mem_rvalid ? t_rd : $urandom;
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        check("issue_cyc", 32'(cyc), 32'd1);
        check("mem_addr", mem_addr, st ? t_addr : {t_addr[31:2], 2'b00});
        check("mem_wen", 32'(mem_wen), 32'(wen_exp));
        if (st) check("mem_wdata", mem_wdata & wd_mask, wd_exp);
      end
      if (resp_valid) begin
        resp_cnt++;
        check("resp_cyc", 32'(cyc), 32'(e_cyc));
        check("resp_rdata", resp_rdata, rd_exp);
        check("adel", 32'(adel), 32'(err && !st));
        check("ades", 32'(ades), 32'(err && st));
        check("timeout", 32'(timeout), 32'(to));
        if (err) check("badvaddr", badvaddr, t_addr);
      end
      if (req_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    check("strobe_count", 32'(en_cnt), err ? 32'd0 : 32'd1);
    check("resp_count", 32'(resp_cnt), (fl == 0) ? 32'd1 : 32'd0);
    check("ready_cyc", 32'(ready_cyc), 32'(ready_exp));
    @(posedge clk); #1;
    flush = 1'b0; mem_rvalid = 1'b0;
    if (ready_cyc == 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  logic [5:0] ops [12];

  initial begin
    logic [5:0]  r_op;
    logic [31:0] r_addr;
    int r_dly, r_fl;

    ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
    rst = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0; rt_old = '0;
    flush = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_flags", {29'd0, adel, ades, timeout}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_badvaddr", badvaddr, 32'd0);
    @(posedge clk); #1;

    run_txn(OP_LB,  32'h0000_1003, 32'h0,         32'h0,         32'h80FF_0000, 0, 0);
    run_txn(OP_SH,  32'h0000_2002, 32'h0000_1234, 32'h0,         32'h0,         0, 0);
    run_txn(OP_LW,  32'h0000_3001, 32'h0,         32'h0,         32'h0,         0, 0);
    run_txn(OP_LWL, 32'h0000_4001, 32'h0,         32'h1122_3344, 32'hAABB_CCDD, 0, 0);
    run_txn(OP_LWR, 32'h0000_4002, 32'h0,         32'h1122_3344, 32'hAABB_CCDD, 1, 0);
    run_txn(OP_SWL, 32'h0000_4401, 32'hA1B2_C3D4, 32'h0,         32'h0,         0, 0);
    run_txn(OP_SWR, 32'h0000_4402, 32'hA1B2_C3D4, 32'h0,         32'h0,         0, 0);
    run_txn(OP_SW,  32'h0000_4406, 32'h0,         32'h0,         32'h0,         0, 0);
    run_txn(OP_LW,  32'h0000_5000, 32'h0,         32'h0,         32'hDEAD_BEEF, 2, 2);
    run_txn(OP_LW,  32'h0000_6000, 32'h0,         32'h0,         32'hDEAD_BEEF, 100, 0);
    run_txn(OP_LW,  32'h0000_6004, 32'h0,         32'h0,         32'h1234_5678, MAX_WAIT - 1, 0);
    run_txn(OP_LBU, 32'h0000_6005, 32'h0,         32'h0,         32'h00C3_0000, 0, 3);
    run_txn(OP_LHU, 32'h0000_6006, 32'h0,         32'h0,         32'hBEEF_0000, 1, 3);
    run_txn(OP_SB,  32'h0000_6007, 32'h0000_005A, 32'h0,         32'h0,         3, 1);

    // Flush together with a request in IDLE: nothing is accepted
    req_valid = 1'b1; op = OP_LW; addr = 32'h0000_8000; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 32'(req_ready), 32'd1);
    check("flush_idle_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of WAIT, then a stale bus response in IDLE
    req_valid = 1'b1; op = OP_LW; addr = 32'h0000_7000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_mem_en", 32'(mem_en), 32'd0);
    check("rstw_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_rvalid_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_resp2", 32'(resp_valid), 32'd0);
    check("late_rvalid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      r_op   = ops[$urandom_range(0, 11)];
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) r_dly = $urandom_range(MAX_WAIT - 1, MAX_WAIT + 2);
      else                           r_dly = $urandom_range(0, 3);
      r_fl = 0;
      if ($urandom_range(0, 5) == 0) r_fl = $urandom_range(1, end_cyc(m_err(r_op, r_addr), r_dly));
      run_txn(r_op, r_addr, $urandom, $urandom, $urandom, r_dly, r_fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
